// File: rtl/layer_4_fmap_sequencer.sv
// layer_4_fmap_sequencer
//   Purpose : walks one convolution layer through NUM_FMAPS output maps. Each map
//             gets a one-cycle fmap_load, then IMG_SIZE*IMG_SIZE buffer reads whose
//             data (one cycle later) is flagged to the featuremap unit through
//             pix_valid. The unit's valid_out pulses are counted until the map is
//             complete, then the next map is loaded. done pulses at the end of the
//             layer.
//   Latency : 1 load cycle + N read cycles (plus stall cycles) + drain cycles per map.
//             pix_valid trails rd_en by exactly 1 cycle.
//   Backpressure: stall withholds new reads in the same cycle. Reads already issued
//             still produce pix_valid. abort abandons the run on the next edge.
// Ports
//   Clk, Rst       clock, asynchronous active-high reset
//   start, abort   run control; start is only sampled in IDLE, abort wins over start
//   stall          holds off buffer reads
//   rd_en, rd_addr input-buffer read strobe / pixel address (read latency 1)
//   pix_valid      valid_in of the selected featuremap unit
//   fmap_load      1-cycle select/initialise pulse for unit fmap_idx
//   fmap_idx       output map in progress
//   fm_valid_out   valid_out pulse from the selected unit
//   busy, done     not-IDLE status / end-of-layer pulse
//   err            sticky error: extra unit output or drain timeout
module layer_4_fmap_sequencer #(
  parameter int IMG_SIZE      = 104,
  parameter int NUM_FMAPS     = 256,
  parameter int DRAIN_TIMEOUT = 4096,
  parameter int ADDR_W        = $clog2(IMG_SIZE*IMG_SIZE),
  parameter int FMAP_W        = $clog2(NUM_FMAPS)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              start,
  input  logic              abort,
  input  logic              stall,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              pix_valid,
  output logic              fmap_load,
  output logic [FMAP_W-1:0] fmap_idx,
  input  logic              fm_valid_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int NPIX  = IMG_SIZE * IMG_SIZE;
  // out_cnt must be able to hold N itself, so it is one bit wider than an address.
  localparam int CNT_W = ADDR_W + 1;
  localparam int TMO_W = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [CNT_W-1:0]  N_OUT     = CNT_W'(NPIX);
  localparam logic [CNT_W-1:0]  N_OUT_M1  = CNT_W'(NPIX - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(DRAIN_TIMEOUT - 1);
  localparam logic [FMAP_W-1:0] LAST_MAP  = FMAP_W'(NUM_FMAPS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pix_cnt;
  logic [CNT_W-1:0]  out_cnt;
  logic [TMO_W-1:0]  tmo_cnt;

  logic issue;
  logic out_ok;
  logic out_bad;
  logic map_complete;

  // The read strobe reacts to stall in the same cycle so that no read is ever
  // issued while stall is high; a registered strobe would leak one read.
  // A read is also withheld in the abort cycle since its data would be orphaned.
  assign issue   = (state == S_STREAM) && !stall && !abort;
  assign rd_en   = issue;
  assign rd_addr = pix_cnt;

  // Classify a unit output: counted while a map is active and not yet full,
  // otherwise it is an unexpected pulse and flags an error.
  always_comb begin
    out_ok  = 1'b0;
    out_bad = 1'b0;
    if (fm_valid_out) begin
      if (((state == S_STREAM) || (state == S_DRAIN)) && (out_cnt != N_OUT)) begin
        out_ok = 1'b1;
      end else begin
        out_bad = 1'b1;
      end
    end
  end

  // Map is complete if already full or the final output arrives this cycle.
  assign map_complete = (out_cnt == N_OUT) || (out_ok && (out_cnt == N_OUT_M1));

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= S_IDLE;
      pix_cnt   <= '0;
      out_cnt   <= '0;
      tmo_cnt   <= '0;
      fmap_idx  <= '0;
      pix_valid <= 1'b0;
      fmap_load <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      // Buffer read latency is one cycle; an in-flight read survives abort.
      pix_valid <= issue;
      fmap_load <= 1'b0;
      done      <= 1'b0;

      if (out_bad) begin
        err <= 1'b1;
      end
      if (out_ok) begin
        out_cnt <= out_cnt + CNT_W'(1);
      end

      if (abort && (state != S_IDLE)) begin
        state   <= S_IDLE;
        busy    <= 1'b0;
        pix_cnt <= '0;
        out_cnt <= '0;
        tmo_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !abort) begin
              state     <= S_LOAD;
              fmap_idx  <= '0;
              // start clears err, but a stray output in the same cycle still counts
              err       <= out_bad;
              fmap_load <= 1'b1;
              busy      <= 1'b1;
            end
          end

          S_LOAD: begin
            pix_cnt <= '0;
            out_cnt <= '0;
            tmo_cnt <= '0;
            state   <= S_STREAM;
          end

          S_STREAM: begin
            if (issue) begin
              // pix_cnt parks on the last address instead of wrapping
              if (pix_cnt == LAST_ADDR) begin
                state   <= S_DRAIN;
                tmo_cnt <= '0;
              end else begin
                pix_cnt <= pix_cnt + ADDR_W'(1);
              end
            end
          end

          S_DRAIN: begin
            if (map_complete) begin
              if (fmap_idx == LAST_MAP) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                fmap_idx  <= fmap_idx + FMAP_W'(1);
                state     <= S_LOAD;
                fmap_load <= 1'b1;
              end
            end else if (tmo_cnt == TMO_LAST) begin
              // the counter would reach DRAIN_TIMEOUT on this edge
              err   <= 1'b1;
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
          end

          S_DONE: begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            pix_cnt <= '0;
            out_cnt <= '0;
            tmo_cnt <= '0;
          end

          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
